// File: rtl/seq_controller_pkg.sv
// Shared types and encodings for the fetch/decode/execute sequencer.
// Instruction fields come from IR[15:13] (opcode) and IR[12:11] (op).
`timescale 1ns/1ps
package seq_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RST    = 5'd0,
      S_IDLE   = 5'd1,
      S_IF1    = 5'd2,
      S_IF2    = 5'd3,
      S_UPC    = 5'd4,
      S_DEC    = 5'd5,
      S_WIMM   = 5'd6,
      S_GA     = 5'd7,
      S_GB     = 5'd8,
      S_CALC   = 5'd9,
      S_CALC_A = 5'd10,
      S_WRD    = 5'd11,
      S_CMP    = 5'd12,
      S_ADDR   = 5'd13,
      S_LADDR  = 5'd14,
      S_ATURN  = 5'd15,
      S_MRD    = 5'd16,
      S_WMEM   = 5'd17,
      S_GRD    = 5'd18,
      S_PASS   = 5'd19,
      S_MWR    = 5'd20,
      S_HALT   = 5'd21,
      S_ERR    = 5'd22
   } state_t;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RM   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RN   = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   // States that hold for MEM_LAT cycles while the memory responds.
   function automatic logic is_mem_state(input state_t st);
      return (st == S_IF1) || (st == S_MRD) || (st == S_MWR);
   endfunction

endpackage

// File: rtl/seq_controller_lat_counter.sv
// Memory latency counter: counts MEM_LAT cycles of an access, up from 0
// or down from MEM_LAT-1, and flags the final cycle on o_done.
`timescale 1ns/1ps
module lat_counter #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_en,
   input  logic i_down,
   output logic o_done
);

   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

   logic [3:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_down ? LAST : '0;
      end else if (i_en) begin
         r_cnt <= i_down ? (r_cnt - 4'd1) : (r_cnt + 4'd1);
      end
   end

   assign o_done = i_en && (i_down ? (r_cnt == '0) : (r_cnt == LAST));

endmodule

// File: rtl/seq_controller.sv
// Fetch/decode/execute sequencer for the simple RISC datapath.
// Moore machine: every output is decoded from the state register alone.
`timescale 1ns/1ps
module seq_controller
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned AUTO_RUN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       reset_pc,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_addr,
   output logic       addr_sel,
   output logic [1:0] mem_cmd,
   output logic       w,
   output logic       halted,
   output logic       err
);

   state_t     r_state;
   state_t     w_next;
   state_t     w_seq_end;
   logic [4:0] w_ir;
   logic       w_cnt_en;
   logic       w_cnt_load;
   logic       w_cnt_done;
   logic       w_is_mem;
   logic       w_calc_a;

   assign w_ir      = {opcode, op};
   assign w_seq_end = (AUTO_RUN != 0) ? S_IF1 : S_IDLE;
   assign w_is_mem  = (opcode == OPC_LDR) || (opcode == OPC_STR);
   assign w_calc_a  = (w_ir == {OPC_MOV, OP_MOV_REG}) || (w_ir == {OPC_ALU, OP_MVN});

   // Counter is parked at its start value outside access states and on the
   // last access cycle, so back-to-back accesses (MWR -> IF1) restart cleanly.
   assign w_cnt_en   = is_mem_state(r_state);
   assign w_cnt_load = !w_cnt_en || w_cnt_done;

   lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_counter (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_load  (w_cnt_load),
      .i_en    (w_cnt_en),
      .i_down  (1'b0),
      .o_done  (w_cnt_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RST;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    w_next = w_seq_end;
         S_IDLE:   if (s) w_next = S_IF1;
         S_IF1:    if (w_cnt_done) w_next = S_IF2;
         S_IF2:    w_next = S_UPC;
         S_UPC:    w_next = S_DEC;
         S_DEC: begin
            if (opcode == OPC_HALT) begin
               w_next = S_HALT;
            end else begin
               case (w_ir)
                  {OPC_MOV, OP_MOV_IMM}: w_next = S_WIMM;
                  {OPC_MOV, OP_MOV_REG}: w_next = S_GB;
                  {OPC_ALU, OP_ADD}:     w_next = S_GA;
                  {OPC_ALU, OP_AND}:     w_next = S_GA;
                  {OPC_ALU, OP_CMP}:     w_next = S_GA;
                  {OPC_ALU, OP_MVN}:     w_next = S_GB;
                  {OPC_LDR, OP_MEM}:     w_next = S_GA;
                  {OPC_STR, OP_MEM}:     w_next = S_GA;
                  default:               w_next = S_ERR;
               endcase
            end
         end
         S_GA:     w_next = w_is_mem ? S_ADDR : S_GB;
         S_GB: begin
            if (w_ir == {OPC_ALU, OP_CMP}) begin
               w_next = S_CMP;
            end else if (w_calc_a) begin
               w_next = S_CALC_A;
            end else begin
               w_next = S_CALC;
            end
         end
         S_CALC:   w_next = S_WRD;
         S_CALC_A: w_next = S_WRD;
         S_WRD:    w_next = w_seq_end;
         S_CMP:    w_next = w_seq_end;
         S_WIMM:   w_next = w_seq_end;
         S_ADDR:   w_next = S_LADDR;
         // One dead cycle lets the freshly loaded address settle at memory.
         S_LADDR:  w_next = S_ATURN;
         S_ATURN:  w_next = (opcode == OPC_LDR) ? S_MRD : S_GRD;
         S_MRD:    if (w_cnt_done) w_next = S_WMEM;
         S_WMEM:   w_next = w_seq_end;
         S_GRD:    w_next = S_PASS;
         S_PASS:   w_next = S_MWR;
         S_MWR:    if (w_cnt_done) w_next = w_seq_end;
         S_HALT:   w_next = S_HALT;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_ERR;
      endcase
   end

   always_comb begin
      nsel      = NSEL_NONE;
      vsel      = VSEL_C;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      write     = 1'b0;
      reset_pc  = 1'b0;
      load_pc   = 1'b0;
      load_ir   = 1'b0;
      load_addr = 1'b0;
      addr_sel  = 1'b0;
      mem_cmd   = MNONE;
      w         = 1'b0;
      halted    = 1'b0;
      err       = 1'b0;
      case (r_state)
         S_RST: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
         end
         S_IDLE:   w = 1'b1;
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = MREAD;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = MREAD;
            load_ir  = 1'b1;
         end
         S_UPC:    load_pc = 1'b1;
         S_WIMM: begin
            nsel  = NSEL_RN;
            vsel  = VSEL_IMM;
            write = 1'b1;
         end
         S_GA: begin
            nsel  = NSEL_RN;
            loada = 1'b1;
         end
         S_GB: begin
            nsel  = NSEL_RM;
            loadb = 1'b1;
         end
         S_CALC:   loadc = 1'b1;
         S_CALC_A: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_WRD: begin
            nsel  = NSEL_RD;
            vsel  = VSEL_C;
            write = 1'b1;
         end
         S_CMP:    loads = 1'b1;
         S_ADDR: begin
            bsel  = 1'b1;
            loadc = 1'b1;
         end
         S_LADDR:  load_addr = 1'b1;
         S_MRD:    mem_cmd = MREAD;
         S_WMEM: begin
            nsel  = NSEL_RD;
            vsel  = VSEL_MDATA;
            write = 1'b1;
         end
         S_GRD: begin
            nsel  = NSEL_RD;
            loadb = 1'b1;
         end
         S_PASS: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_MWR:    mem_cmd = MWRITE;
         S_HALT:   halted = 1'b1;
         S_ERR:    err = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: three instances cover AUTO_RUN=1/LAT=1,
// AUTO_RUN=1/LAT=3 and AUTO_RUN=0/LAT=1; one runs while the others sit in reset.
`timescale 1ns/1ps
module tb_seq_controller;

   typedef struct packed {
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic       reset_pc;
      logic       load_pc;
      logic       load_ir;
      logic       load_addr;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       w;
      logic       halted;
      logic       err;
   } ctl_t;

   logic       clk;
   logic       rst_a, rst_b, rst_c;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   ctl_t       oa, ob, oc;
   int         n_checks;
   int         n_errors;

   seq_controller #(.MEM_LAT(1), .AUTO_RUN(1)) u_a (
      .clk(clk), .reset(rst_a), .s(s), .opcode(opcode), .op(op),
      .nsel(oa.nsel), .vsel(oa.vsel), .loada(oa.loada), .loadb(oa.loadb),
      .loadc(oa.loadc), .loads(oa.loads), .asel(oa.asel), .bsel(oa.bsel),
      .write(oa.write), .reset_pc(oa.reset_pc), .load_pc(oa.load_pc),
      .load_ir(oa.load_ir), .load_addr(oa.load_addr), .addr_sel(oa.addr_sel),
      .mem_cmd(oa.mem_cmd), .w(oa.w), .halted(oa.halted), .err(oa.err)
   );

   seq_controller #(.MEM_LAT(3), .AUTO_RUN(1)) u_b (
      .clk(clk), .reset(rst_b), .s(s), .opcode(opcode), .op(op),
      .nsel(ob.nsel), .vsel(ob.vsel), .loada(ob.loada), .loadb(ob.loadb),
      .loadc(ob.loadc), .loads(ob.loads), .asel(ob.asel), .bsel(ob.bsel),
      .write(ob.write), .reset_pc(ob.reset_pc), .load_pc(ob.load_pc),
      .load_ir(ob.load_ir), .load_addr(ob.load_addr), .addr_sel(ob.addr_sel),
      .mem_cmd(ob.mem_cmd), .w(ob.w), .halted(ob.halted), .err(ob.err)
   );

   seq_controller #(.MEM_LAT(1), .AUTO_RUN(0)) u_c (
      .clk(clk), .reset(rst_c), .s(s), .opcode(opcode), .op(op),
      .nsel(oc.nsel), .vsel(oc.vsel), .loada(oc.loada), .loadb(oc.loadb),
      .loadc(oc.loadc), .loads(oc.loads), .asel(oc.asel), .bsel(oc.bsel),
      .write(oc.write), .reset_pc(oc.reset_pc), .load_pc(oc.load_pc),
      .load_ir(oc.load_ir), .load_addr(oc.load_addr), .addr_sel(oc.addr_sel),
      .mem_cmd(oc.mem_cmd), .w(oc.w), .halted(oc.halted), .err(oc.err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hand-written expected output vector for each state name.
   function automatic ctl_t ev(input string st);
      ctl_t e;
      e = '0;
      case (st)
         "RST":    begin e.reset_pc = 1'b1; e.load_pc = 1'b1; end
         "IDLE":   e.w = 1'b1;
         "IF1":    begin e.addr_sel = 1'b1; e.mem_cmd = 2'b01; end
         "IF2":    begin e.addr_sel = 1'b1; e.mem_cmd = 2'b01; e.load_ir = 1'b1; end
         "UPC":    e.load_pc = 1'b1;
         "DEC":    ;
         "WIMM":   begin e.nsel = 3'b100; e.vsel = 2'b10; e.write = 1'b1; end
         "GA":     begin e.nsel = 3'b100; e.loada = 1'b1; end
         "GB":     begin e.nsel = 3'b001; e.loadb = 1'b1; end
         "CALC":   e.loadc = 1'b1;
         "CALC_A": begin e.asel = 1'b1; e.loadc = 1'b1; end
         "WRD":    begin e.nsel = 3'b010; e.vsel = 2'b00; e.write = 1'b1; end
         "CMP":    e.loads = 1'b1;
         "ADDR":   begin e.bsel = 1'b1; e.loadc = 1'b1; end
         "LADDR":  e.load_addr = 1'b1;
         "ATURN":  ;
         "MRD":    e.mem_cmd = 2'b01;
         "WMEM":   begin e.nsel = 3'b010; e.vsel = 2'b11; e.write = 1'b1; end
         "GRD":    begin e.nsel = 3'b010; e.loadb = 1'b1; end
         "PASS":   begin e.asel = 1'b1; e.loadc = 1'b1; end
         "MWR":    e.mem_cmd = 2'b10;
         "HALT":   e.halted = 1'b1;
         "ERR":    e.err = 1'b1;
         default:  e = '1;
      endcase
      return e;
   endfunction

   function automatic ctl_t get_out(input int unsigned k);
      case (k)
         0:       return oa;
         1:       return ob;
         default: return oc;
      endcase
   endfunction

   function automatic string inst_name(input int unsigned k);
      case (k)
         0:       return "A";
         1:       return "B";
         default: return "C";
      endcase
   endfunction

   task automatic now_chk(input int unsigned k, input string st);
      #1;
      check($sformatf("%s_%s_async@%0t", inst_name(k), st, $time),
            32'(get_out(k)), 32'(ev(st)));
   endtask

   task automatic step(input int unsigned k, input string st);
      @(posedge clk);
      #1;
      check($sformatf("%s_%s@%0t", inst_name(k), st, $time),
            32'(get_out(k)), 32'(ev(st)));
   endtask

   task automatic setir(input logic [2:0] oc_v, input logic [1:0] op_v);
      opcode = oc_v;
      op     = op_v;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      s = 1'b0;
      setir(3'b000, 2'b00);

      // ---- A: AUTO_RUN=1, MEM_LAT=1 ----
      step(0, "RST"); step(0, "RST"); step(0, "RST");
      setir(3'b110, 2'b10);
      rst_a = 1'b1;
      step(0, "IF1"); step(0, "IF2"); step(0, "UPC"); step(0, "DEC"); step(0, "WIMM");
      step(0, "IF1");
      setir(3'b101, 2'b00);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC");
      step(0, "GA"); step(0, "GB"); step(0, "CALC"); step(0, "WRD"); step(0, "IF1");
      setir(3'b101, 2'b11);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC");
      step(0, "GB"); step(0, "CALC_A"); step(0, "WRD"); step(0, "IF1");
      setir(3'b101, 2'b01);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC");
      step(0, "GA"); step(0, "GB"); step(0, "CMP"); step(0, "IF1");
      setir(3'b110, 2'b00);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC");
      step(0, "GB"); step(0, "CALC_A"); step(0, "WRD"); step(0, "IF1");
      setir(3'b101, 2'b10);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC");
      step(0, "GA"); step(0, "GB"); step(0, "CALC"); step(0, "WRD"); step(0, "IF1");
      setir(3'b011, 2'b00);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC"); step(0, "GA"); step(0, "ADDR");
      step(0, "LADDR"); step(0, "ATURN"); step(0, "MRD"); step(0, "WMEM"); step(0, "IF1");
      setir(3'b100, 2'b00);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC"); step(0, "GA"); step(0, "ADDR");
      step(0, "LADDR"); step(0, "ATURN"); step(0, "GRD"); step(0, "PASS"); step(0, "MWR");
      step(0, "IF1");
      setir(3'b111, 2'b01);
      step(0, "IF2"); step(0, "UPC"); step(0, "DEC"); step(0, "HALT");
      for (int i = 0; i < 20; i++) begin
         s = ~s;
         step(0, "HALT");
      end
      s = 1'b0;
      rst_a = 1'b0;
      now_chk(0, "RST");
      step(0, "RST");
      setir(3'b000, 2'b00);
      rst_a = 1'b1;
      step(0, "IF1"); step(0, "IF2"); step(0, "UPC"); step(0, "DEC"); step(0, "ERR");
      setir(3'b110, 2'b10);
      for (int i = 0; i < 5; i++) begin
         s = ~s;
         step(0, "ERR");
      end
      s = 1'b0;
      rst_a = 1'b0;
      now_chk(0, "RST");

      // ---- B: AUTO_RUN=1, MEM_LAT=3 ----
      setir(3'b011, 2'b00);
      rst_b = 1'b1;
      step(1, "IF1"); step(1, "IF1"); step(1, "IF1");
      step(1, "IF2"); step(1, "UPC"); step(1, "DEC"); step(1, "GA"); step(1, "ADDR");
      step(1, "LADDR"); step(1, "ATURN");
      step(1, "MRD"); step(1, "MRD"); step(1, "MRD");
      step(1, "WMEM"); step(1, "IF1"); step(1, "IF1"); step(1, "IF1");
      setir(3'b100, 2'b00);
      step(1, "IF2"); step(1, "UPC"); step(1, "DEC"); step(1, "GA"); step(1, "ADDR");
      step(1, "LADDR"); step(1, "ATURN"); step(1, "GRD"); step(1, "PASS");
      step(1, "MWR"); step(1, "MWR"); step(1, "MWR");
      step(1, "IF1"); step(1, "IF1"); step(1, "IF1");
      step(1, "IF2"); step(1, "UPC"); step(1, "DEC"); step(1, "GA"); step(1, "ADDR");
      step(1, "LADDR"); step(1, "ATURN"); step(1, "GRD"); step(1, "PASS");
      step(1, "MWR"); step(1, "MWR");
      rst_b = 1'b0;
      now_chk(1, "RST");
      step(1, "RST");
      rst_b = 1'b1;
      step(1, "IF1"); step(1, "IF1"); step(1, "IF1"); step(1, "IF2");
      rst_b = 1'b0;

      // ---- C: AUTO_RUN=0, MEM_LAT=1 ----
      setir(3'b101, 2'b00);
      rst_c = 1'b1;
      step(2, "IDLE"); step(2, "IDLE"); step(2, "IDLE");
      s = 1'b1;
      step(2, "IF1");
      s = 1'b0;
      step(2, "IF2"); step(2, "UPC"); step(2, "DEC"); step(2, "GA"); step(2, "GB");
      step(2, "CALC"); step(2, "WRD"); step(2, "IDLE"); step(2, "IDLE");
      s = 1'b1;
      step(2, "IF1");
      s = 1'b0;
      step(2, "IF2"); step(2, "UPC"); step(2, "DEC"); step(2, "GA"); step(2, "GB");
      step(2, "CALC"); step(2, "WRD");
      rst_c = 1'b0;
      now_chk(2, "RST");
      step(2, "RST");
      rst_c = 1'b1;
      step(2, "IDLE");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
